match_timer_ctrl: RTL

//  Sequences the time-mode match clock for the pong game. An internal prescaler

---
 rtl/pong_timer_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 25 ++
 rtl/match_timer_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/pong_timer_pkg.sv
// pong_timer_pkg: shared states, BCD limits and helpers for the match timer
package pong_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam int unsigned TICK_DIV_HW = 100_000_000;

    // Saturate each preset digit to its legal BCD range
    function automatic logic [11:0] clamp_preset(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        return {(m > DIGIT_MAX) ? DIGIT_MAX : m,
                (t > SEC_T_MAX) ? SEC_T_MAX : t,
                (o > DIGIT_MAX) ? DIGIT_MAX : o};
    endfunction

    // One-second decrement of a packed {min, sec_t, sec_o} BCD value
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        if (v[3:0] != 4'd0)
            return {v[11:4], v[3:0] - 4'd1};
        if (v[7:4] != 4'd0)
            return {v[11:8], v[7:4] - 4'd1, DIGIT_MAX};
        return {v[11:8] - 4'd1, SEC_T_MAX, DIGIT_MAX};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock into a one-cycle tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_W'(TICK_DIV - 1));

    // Count only while enabled; hold otherwise so a paused second resumes where it stopped
    always_ff @(posedge clock) begin
        if (!rst_n || clr)
            count <= '0;
        else if (en)
            count <= tick ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl: start/pause/abort FSM and BCD mm:ss countdown for the pong match clock
module match_timer_ctrl
    import pong_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_HW,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       abort,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_t,
    input  logic [3:0] load_sec_o,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       expire_pulse,
    output logic       tick_1hz
);

    state_t      state, state_n;
    logic [11:0] disp, disp_n, preset, dec;
    logic        tick_n, xp_n, clr, presc_tick;

    tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_presc (
        .clock(clock),
        .rst_n(rst_n),
        .en   (state == ST_RUN),
        .clr  (clr),
        .tick (presc_tick)
    );

    assign preset = clamp_preset(load_min, load_sec_t, load_sec_o);
    assign dec    = bcd_dec(disp);

    assign {min, sec_t, sec_o} = disp;
    assign running = state == ST_RUN;
    assign paused  = state == ST_PAUSE;
    assign expired = state == ST_EXPIRED;

    // Register state, display digits and the two pulse outputs
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            disp         <= '0;
            tick_1hz     <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            disp         <= disp_n;
            tick_1hz     <= tick_n;
            expire_pulse <= xp_n;
        end
    end

    // Next state and datapath: abort beats start beats pause_tgl
    always_comb begin
        state_n = state;
        disp_n  = disp;
        tick_n  = 1'b0;
        xp_n    = 1'b0;
        clr     = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            disp_n  = preset;
            clr     = 1'b1;
        end else if ((state == ST_IDLE || state == ST_EXPIRED) && start) begin
            clr     = 1'b1;
            disp_n  = preset;
            xp_n    = preset == 12'd0;
            state_n = (preset == 12'd0) ? ST_EXPIRED : ST_RUN;
        end else if (state == ST_IDLE) begin
            disp_n = preset;
        end else if (state == ST_RUN && presc_tick) begin
            disp_n  = dec;
            tick_n  = 1'b1;
            xp_n    = dec == 12'd0;
            state_n = (dec == 12'd0) ? ST_EXPIRED : pause_tgl ? ST_PAUSE : ST_RUN;
        end else if (state == ST_RUN && pause_tgl) begin
            state_n = ST_PAUSE;
        end else if (state == ST_PAUSE && pause_tgl) begin
            state_n = ST_RUN;
        end
    end

endmodule
